// File: rtl/unidade_controle_if.sv
// Signal bundle between the control unit and the 8-bit datapath it sequences.
// master is the control unit side; slave is the datapath side.
interface unidade_controle_if;
    logic [7:0] IR;
    logic [3:0] CCR_Result;
    logic [2:0] Bus1_Sel;
    logic [1:0] Bus2_Sel;
    logic       PC_Load;
    logic       PC_Inc;
    logic       PR_Inc;
    logic       A_Load;
    logic       B_Load;
    logic       C_Load;
    logic       IR_Load;
    logic       MAR_Load;
    logic       CCR_Load;
    logic       Memory_Load;
    logic [2:0] ALU_Sel;
    logic       halted;

    modport master (
        input  IR, CCR_Result,
        output Bus1_Sel, Bus2_Sel, PC_Load, PC_Inc, PR_Inc, A_Load, B_Load, C_Load,
               IR_Load, MAR_Load, CCR_Load, Memory_Load, ALU_Sel, halted
    );

    modport slave (
        output IR, CCR_Result,
        input  Bus1_Sel, Bus2_Sel, PC_Load, PC_Inc, PR_Inc, A_Load, B_Load, C_Load,
               IR_Load, MAR_Load, CCR_Load, Memory_Load, ALU_Sel, halted
    );
endinterface

// File: rtl/unidade_controle.sv
// Moore control unit for the 8-bit datapath: fetch, decode and execute of a
// small load/store/ALU/branch instruction set, driving every select and strobe.
module unidade_controle #(
    parameter logic [2:0] ALU_ADD = 3'b000,
    parameter logic [2:0] ALU_SUB = 3'b001
) (
    input logic                clock,
    input logic                reset,
    unidade_controle_if.master ctrl
);
    localparam logic [7:0] OP_LDA_IMM = 8'h86;
    localparam logic [7:0] OP_LDA_DIR = 8'h87;
    localparam logic [7:0] OP_LDB_IMM = 8'h88;
    localparam logic [7:0] OP_LDB_DIR = 8'h89;
    localparam logic [7:0] OP_STA_DIR = 8'h96;
    localparam logic [7:0] OP_STB_DIR = 8'h97;
    localparam logic [7:0] OP_ADD_AB  = 8'h42;
    localparam logic [7:0] OP_SUB_AB  = 8'h43;
    localparam logic [7:0] OP_MOV_AC  = 8'h44;
    localparam logic [7:0] OP_CNT     = 8'h50;
    localparam logic [7:0] OP_BRA     = 8'h20;
    localparam logic [7:0] OP_BEQ     = 8'h23;
    localparam logic [7:0] OP_HALT    = 8'hFF;

    localparam logic [2:0] B1_PC   = 3'b000;
    localparam logic [2:0] B1_A    = 3'b001;
    localparam logic [2:0] B1_B    = 3'b010;
    localparam logic [1:0] B2_BUS1 = 2'b00;
    localparam logic [1:0] B2_MEM  = 2'b10;
    localparam logic [1:0] B2_ALU  = 2'b11;

    // Operand fetch (S_OPND_4/5) is shared by all load/store opcodes; IR picks the tail.
    typedef enum logic [4:0] {
        S_FETCH_0, S_FETCH_1, S_FETCH_2, S_DECODE_3,
        S_OPND_4, S_OPND_5,
        S_LDA_IMM_6, S_LDB_IMM_6,
        S_DIR_6, S_LD_DIR_7, S_LDA_DIR_8, S_LDB_DIR_8,
        S_STA_DIR_7, S_STB_DIR_7,
        S_ADD_4, S_SUB_4, S_MOV_AC_4, S_CNT_4,
        S_BRA_4, S_BRA_5, S_BRA_6,
        S_BEQ_SKIP_4,
        S_HALT
    } state_t;

    state_t state;
    state_t state_next;
    logic   z_flag;

    assign z_flag = ctrl.CCR_Result[2];

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_FETCH_0;
        else       state <= state_next;
    end

    // NOTE: next state defaults to S_FETCH_0 before the case, so no latch is inferred and
    // any unreachable encoding falls back to a fresh fetch.
    always_comb begin
        state_next = S_FETCH_0;
        case (state)
            S_FETCH_0:  state_next = S_FETCH_1;
            S_FETCH_1:  state_next = S_FETCH_2;
            S_FETCH_2:  state_next = S_DECODE_3;
            S_DECODE_3: begin
                case (ctrl.IR)
                    OP_LDA_IMM, OP_LDB_IMM, OP_LDA_DIR,
                    OP_LDB_DIR, OP_STA_DIR, OP_STB_DIR: state_next = S_OPND_4;
                    OP_ADD_AB: state_next = S_ADD_4;
                    OP_SUB_AB: state_next = S_SUB_4;
                    OP_MOV_AC: state_next = S_MOV_AC_4;
                    OP_CNT:    state_next = S_CNT_4;
                    OP_BRA:    state_next = S_BRA_4;
                    OP_BEQ:    state_next = z_flag ? S_BRA_4 : S_BEQ_SKIP_4;
                    OP_HALT:   state_next = S_HALT;
                    default:   state_next = S_FETCH_0;
                endcase
            end
            S_OPND_4: state_next = S_OPND_5;
            S_OPND_5: begin
                if (ctrl.IR == OP_LDA_IMM)      state_next = S_LDA_IMM_6;
                else if (ctrl.IR == OP_LDB_IMM) state_next = S_LDB_IMM_6;
                else                            state_next = S_DIR_6;
            end
            S_DIR_6: begin
                if (ctrl.IR == OP_STA_DIR)      state_next = S_STA_DIR_7;
                else if (ctrl.IR == OP_STB_DIR) state_next = S_STB_DIR_7;
                else                            state_next = S_LD_DIR_7;
            end
            S_LD_DIR_7: state_next = (ctrl.IR == OP_LDA_DIR) ? S_LDA_DIR_8 : S_LDB_DIR_8;
            S_BRA_4:    state_next = S_BRA_5;
            S_BRA_5:    state_next = S_BRA_6;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH_0;
        endcase
    end

    // NOTE: outputs are gated by reset combinationally so they drop in the same cycle
    // reset rises, not at the next clock edge.
    always_comb begin
        ctrl.Bus1_Sel    = B1_PC;
        ctrl.Bus2_Sel    = B2_BUS1;
        ctrl.PC_Load     = 1'b0;
        ctrl.PC_Inc      = 1'b0;
        ctrl.PR_Inc      = 1'b0;
        ctrl.A_Load      = 1'b0;
        ctrl.B_Load      = 1'b0;
        ctrl.C_Load      = 1'b0;
        ctrl.IR_Load     = 1'b0;
        ctrl.MAR_Load    = 1'b0;
        ctrl.CCR_Load    = 1'b0;
        ctrl.Memory_Load = 1'b0;
        ctrl.ALU_Sel     = ALU_ADD;
        ctrl.halted      = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH_0, S_OPND_4, S_BRA_4: ctrl.MAR_Load = 1'b1;
                S_FETCH_1, S_OPND_5, S_BEQ_SKIP_4: ctrl.PC_Inc = 1'b1;
                S_FETCH_2: begin
                    ctrl.Bus2_Sel = B2_MEM;
                    ctrl.IR_Load  = 1'b1;
                end
                S_LDA_IMM_6, S_LDA_DIR_8: begin
                    ctrl.Bus2_Sel = B2_MEM;
                    ctrl.A_Load   = 1'b1;
                end
                S_LDB_IMM_6, S_LDB_DIR_8: begin
                    ctrl.Bus2_Sel = B2_MEM;
                    ctrl.B_Load   = 1'b1;
                end
                S_DIR_6: begin
                    ctrl.Bus2_Sel = B2_MEM;
                    ctrl.MAR_Load = 1'b1;
                end
                S_STA_DIR_7: begin
                    ctrl.Bus1_Sel    = B1_A;
                    ctrl.Memory_Load = 1'b1;
                end
                S_STB_DIR_7: begin
                    ctrl.Bus1_Sel    = B1_B;
                    ctrl.Memory_Load = 1'b1;
                end
                S_ADD_4, S_SUB_4: begin
                    ctrl.ALU_Sel  = (state == S_SUB_4) ? ALU_SUB : ALU_ADD;
                    ctrl.Bus1_Sel = B1_A;
                    ctrl.Bus2_Sel = B2_ALU;
                    ctrl.A_Load   = 1'b1;
                    ctrl.CCR_Load = 1'b1;
                end
                S_MOV_AC_4: begin
                    ctrl.Bus1_Sel = B1_A;
                    ctrl.C_Load   = 1'b1;
                end
                S_CNT_4: ctrl.PR_Inc = 1'b1;
                S_BRA_6: begin
                    ctrl.Bus2_Sel = B2_MEM;
                    ctrl.PC_Load  = 1'b1;
                end
                S_HALT:  ctrl.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
- Moore finite-state controller that sequences the 8-bit processor datapath (registers A, B, C, PC, PR, IR, MAR, CCR and buses Bus1/Bus2).
- Runs fetch, decode and execute for a fixed instruction subset.
- Drives every datapath select and load strobe, plus ALU_Sel for the ALU.
- Reads IR and the CCR flags back from the datapath.

Parameters:
- ALU_ADD, 3'b000, ALU_Sel code for A+B.
- ALU_SUB, 3'b001, ALU_Sel code for A-B.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- IR  in  8  instruction register from datapath.
- CCR_Result  in  4  flags {N,Z,V,C}; Z is bit 2.
- Bus1_Sel  out  3  000 PC, 001 A, 010 B, 011 C, 100 PR, 101 IR.
- Bus2_Sel  out  2  00 Bus1, 01 const 1, 10 from_memory, 11 ALU_Result.
- PC_Load, PC_Inc, PR_Inc, A_Load, B_Load, C_Load, IR_Load, MAR_Load, CCR_Load, Memory_Load  out  1 each  datapath strobes.
- ALU_Sel  out  3  ALU operation.
- halted  out  1  high while in S_HALT.

Behaviour:
- Reset (async, high):
  - state goes to S_FETCH_0.
  - While reset is high, all outputs are forced to 0 (strobes low, selects 0, halted 0).
- Outputs are a pure function of state, plus IR/Z in S_DECODE_3. Each strobe is asserted for exactly one cycle per state.
- Memory timing: from_memory is valid one cycle after MAR is loaded.
- Fetch, 4 cycles, used by every instruction:
  - S_FETCH_0: Bus1_Sel=PC, Bus2_Sel=Bus1, MAR_Load.
  - S_FETCH_1: PC_Inc.
  - S_FETCH_2: Bus2_Sel=from_memory, IR_Load.
  - S_DECODE_3: no strobes; branch on IR.
- Opcodes and execute states (every execute path returns to S_FETCH_0):
  - 0x86 LDA_IMM, 0x88 LDB_IMM:
    - S_4: MAR<=PC.
    - S_5: PC_Inc.
    - S_6: A (or B) <= from_memory.
    - 7 execute-inclusive cycles in total.
  - 0x87 LDA_DIR, 0x89 LDB_DIR:
    - S_4: MAR<=PC.
    - S_5: PC_Inc.
    - S_6: MAR<=from_memory.
    - S_7: wait.
    - S_8: A (or B) <= from_memory.
  - 0x96 STA_DIR, 0x97 STB_DIR:
    - S_4: MAR<=PC.
    - S_5: PC_Inc.
    - S_6: MAR<=from_memory.
    - S_7: Bus1_Sel=A (or B), Memory_Load.
  - 0x42 ADD_AB, 0x43 SUB_AB:
    - S_4: ALU_Sel=ADD/SUB, Bus1_Sel=A, Bus2_Sel=ALU_Result, A_Load, CCR_Load.
  - 0x44 MOV_AC:
    - S_4: Bus1_Sel=A, Bus2_Sel=Bus1, C_Load.
  - 0x50 CNT:
    - S_4: PR_Inc.
  - 0x20 BRA:
    - S_4: MAR<=PC.
    - S_5: wait.
    - S_6: Bus2_Sel=from_memory, PC_Load.
  - 0x23 BEQ:
    - Z is sampled in S_DECODE_3.
    - Z=1: follows the BRA path.
    - Z=0: S_4 is PC_Inc (skip operand), then S_FETCH_0.
  - 0xFF HALT:
    - Goes to S_HALT: no strobes, halted=1.
    - Remains there until reset.
  - Any other opcode: NOP; S_DECODE_3 goes to S_FETCH_0.
- Mutual exclusion:
  - PC_Load and PC_Inc are never asserted together.
  - At most one of A/B/C/IR/MAR_Load is asserted per cycle.
- Reset mid-instruction:
  - Abandons the sequence immediately.
  - No strobe is asserted in the cycle reset is high.
  - After release, restarts at S_FETCH_0.
- State encoding: binary, at most 5 bits. No unreachable state may lock up; the default transition is to S_FETCH_0.

Test Plan:
- Reset release with memory[0]=0x86, [1]=0x5A, [2]=0xFF:
  - MAR_Load in cycle 0, PC_Inc in cycle 1, IR_Load in cycle 2.
  - A_Load with Bus2_Sel=10 in cycle 6.
  - Then HALT: halted=1 from cycle 11 onward, with no further strobes.
- Program LDA_IMM 0x03, LDB_IMM 0x05, ADD_AB, STA_DIR 0x40:
  - One cycle asserts ALU_Sel=000, Bus2_Sel=11, A_Load and CCR_Load together.
  - Memory_Load is asserted with Bus1_Sel=001 after MAR has been loaded with 0x40.
  - Memory[0x40] ends as 0x08.
- BEQ 0x10:
  - With CCR_Result=4'b0100: PC_Load with Bus2_Sel=10, and the next fetch is from address 0x10.
  - With CCR_Result=4'b0000: a single PC_Inc, and the next fetch is from PC+2 of the BEQ address.
- Illegal opcode 0x77, then CNT:
  - 0x77 returns to S_FETCH_0 right after S_DECODE_3 with no strobe.
  - CNT asserts PR_Inc for exactly one cycle.
- Assert reset during S_6 of LDA_DIR:
  - All outputs drop to 0 in the same cycle, asynchronously.
  - After release, MAR_Load with Bus1_Sel=000 occurs on the first cycle.
- Across all the runs above: a monitor asserts that PC_Load&PC_Inc is never high, and that no two register-load strobes are high in the same cycle.
